// File: rtl/perip_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Bytes written to TXDATA are queued
// in a small FIFO and shifted out LSB first on uart_tx.
module perip_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8020_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] perip_addr,
  input  logic        perip_wen,
  input  logic [1:0]  perip_mask,
  input  logic [31:0] perip_wdata,
  output logic [31:0] perip_rdata,
  output logic        uart_tx,
  output logic        irq
);

  localparam int         PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       count;
  logic             overflow;
  logic [15:0]      divisor;
  logic [1:0]       ctrl;
  logic [15:0]      period;
  logic [15:0]      tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;

  logic        hit;
  logic [1:0]  off;
  logic        wr;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        empty;
  logic        full;
  logic        busy;
  logic [15:0] next_period;
  logic        unused_ok;

  assign hit         = perip_addr[31:4] == BASE_ADDR[31:4];
  assign off         = perip_addr[3:2];
  assign wr          = perip_wen && hit;
  assign push_req    = wr && (off == 2'd0);
  assign empty       = count == 5'd0;
  assign full        = count == DEPTH;
  assign busy        = state != IDLE;
  assign next_period = (divisor == 16'd0) ? 16'd1 : divisor;
  assign unused_ok   = ^{perip_addr[1:0], perip_wdata[31:16]};

  // A new frame is loaded from IDLE, or straight out of the last STOP cycle
  // so consecutive frames are seamless; a full FIFO still accepts a byte then.
  assign pop  = ctrl[0] && !empty &&
                ((state == IDLE) || (state == STOP && tick_cnt == 16'd0));
  assign push = push_req && (!full || pop);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= perip_wdata[7:0];
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + 5'd1;
      end else if (pop && !push) begin
        count <= count - 5'd1;
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
      end else if (wr && off == 2'd1 && perip_wdata[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      divisor <= DEFAULT_DIV;
      ctrl    <= 2'b00;
    end else if (wr) begin
      if (off == 2'd2) begin
        divisor[7:0] <= perip_wdata[7:0];
        if (perip_mask != 2'b00) begin
          divisor[15:8] <= perip_wdata[15:8];
        end
      end
      if (off == 2'd3) begin
        ctrl <= perip_wdata[1:0];
      end
    end
  end

  // The bit period is latched per frame, so DIVISOR writes never stretch
  // or shrink a frame already on the wire.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      irq      <= 1'b0;
      shifter  <= 8'd0;
      period   <= 16'd1;
      tick_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else begin
      irq <= empty && (state == IDLE) && ctrl[1];
      if (pop) begin
        shifter  <= mem[rd_ptr];
        period   <= next_period;
        tick_cnt <= next_period - 16'd1;
        uart_tx  <= 1'b0;
        state    <= START;
      end else begin
        case (state)
          IDLE: begin
            uart_tx <= 1'b1;
          end
          START: begin
            if (tick_cnt == 16'd0) begin
              state    <= DATA;
              bit_idx  <= 3'd0;
              uart_tx  <= shifter[0];
              tick_cnt <= period - 16'd1;
            end else begin
              tick_cnt <= tick_cnt - 16'd1;
            end
          end
          DATA: begin
            if (tick_cnt == 16'd0) begin
              tick_cnt <= period - 16'd1;
              if (bit_idx == 3'd7) begin
                state   <= STOP;
                uart_tx <= 1'b1;
              end else begin
                shifter <= shifter >> 1;
                uart_tx <= shifter[1];
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt - 16'd1;
            end
          end
          STOP: begin
            uart_tx <= 1'b1;
            if (tick_cnt == 16'd0) begin
              state <= IDLE;
            end else begin
              tick_cnt <= tick_cnt - 16'd1;
            end
          end
          default: begin
            state   <= IDLE;
            uart_tx <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    perip_rdata = 32'd0;
    if (hit) begin
      case (off)
        2'd1:    perip_rdata = {23'd0, count, overflow, empty, full, busy};
        2'd2:    perip_rdata = {16'd0, divisor};
        2'd3:    perip_rdata = {30'd0, ctrl};
        default: perip_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_perip_uart_tx.sv
// Bench for perip_uart_tx: expected frames are queued as bytes are written and a
// line monitor decodes uart_tx cycle by cycle against the ideal 8N1 waveform.
module tb_perip_uart_tx;

  localparam logic [31:0] BASE     = 32'h8020_0000;
  localparam logic [31:0] TXDATA_A = BASE;
  localparam logic [31:0] STATUS_A = BASE + 32'h4;
  localparam logic [31:0] DIV_A    = BASE + 32'h8;
  localparam logic [31:0] CTRL_A   = BASE + 32'hC;
  localparam int          DEPTH    = 8;

  typedef struct {
    logic [7:0] data;
    int         p;
  } frame_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic [31:0] perip_addr = 32'd0;
  logic        perip_wen = 1'b0;
  logic [1:0]  perip_mask = 2'b00;
  logic [31:0] perip_wdata = 32'd0;
  wire  [31:0] perip_rdata;
  wire         uart_tx;
  wire         irq;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_en = 1'b1;
  frame_t     exp_q[$];
  int         start_q[$];
  logic [7:0] model_fifo[$];
  bit         model_ovf = 1'b0;
  logic [15:0] cur_div = 16'd868;

  perip_uart_tx #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .perip_addr(perip_addr),
    .perip_wen(perip_wen),
    .perip_mask(perip_mask),
    .perip_wdata(perip_wdata),
    .perip_rdata(perip_rdata),
    .uart_tx(uart_tx),
    .irq(irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  function automatic int effP(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  function automatic logic [31:0] modelStatus(input int cnt, input bit ovf, input bit busy);
    return (32'(cnt) << 4) | {28'd0, ovf, (cnt == 0), (cnt == DEPTH), busy};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    @(negedge cpu_clk);
    perip_addr  = a;
    perip_mask  = m;
    perip_wdata = d;
    perip_wen   = 1'b1;
    @(posedge cpu_clk);
    #1;
    perip_wen = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] a, output logic [31:0] d);
    perip_wen  = 1'b0;
    perip_addr = a;
    #1;
    d = perip_rdata;
  endtask

  task automatic checkReg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    readReg(a, d);
    checkOutput(name, d, exp);
  endtask

  task automatic pushByte(input logic [7:0] b, input int p);
    exp_q.push_back('{data: b, p: p});
    applyStimulus(TXDATA_A + 32'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  {24'($urandom), b});
  endtask

  task automatic waitIdle(input int budget);
    logic [31:0] s;
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge cpu_clk);
      readReg(STATUS_A, s);
      if (exp_q.size() == 0 && s[0] == 1'b0) break;
    end
    checks++;
    if (k == budget) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d frames still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Line monitor: every falling start edge consumes one expected frame.
  initial begin : monitor
    frame_t     ent;
    logic [9:0] wave;
    int         bad_cyc;
    logic       bad_val;
    forever begin
      @(negedge cpu_clk);
      if (mon_en && !cpu_rst && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: line low at cycle %0d, required idle high", cyc);
          for (int k = 0; k < 2000 && uart_tx === 1'b0; k++) @(negedge cpu_clk);
        end else begin
          ent     = exp_q.pop_front();
          wave    = {1'b1, ent.data, 1'b0};
          bad_cyc = -1;
          bad_val = 1'b1;
          for (int c = 0; c < 10 * ent.p; c++) begin
            if (c > 0) @(negedge cpu_clk);
            if (!mon_en) break;
            if (uart_tx !== wave[c / ent.p] && bad_cyc < 0) begin
              bad_cyc = c;
              bad_val = uart_tx;
            end
          end
          if (mon_en) begin
            checks++;
            if (bad_cyc >= 0) begin
              errors++;
              $display("[TB] FAIL frame 0x%02h P=%0d: cycle %0d line got %b required %b",
                       ent.data, ent.p, bad_cyc, bad_val, wave[bad_cyc / ent.p]);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] s;
    logic [7:0]  b;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] w;
    logic [1:0]  m;
    int          n;
    int          lows;

    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    $display("[TB] reset state");
    checkReg("rst_status", STATUS_A, 32'h0000_0004);
    checkReg("rst_divisor", DIV_A, 32'd868);
    checkReg("rst_ctrl", CTRL_A, 32'd0);
    checkReg("txdata_reads_zero", TXDATA_A, 32'd0);
    checkReg("nohit_read", STATUS_A + 32'h10, 32'd0);
    checkOutput("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);

    $display("[TB] single frame 0xA5 at P=4");
    applyStimulus(DIV_A, 2'b10, 32'd4);
    cur_div = 16'd4;
    applyStimulus(CTRL_A, 2'b10, 32'd1);
    exp_q.push_back('{data: 8'hA5, p: 4});
    applyStimulus(TXDATA_A, 2'b00, 32'h0000_00A5);
    @(negedge cpu_clk);
    checkOutput("latency_still_idle", {31'd0, uart_tx}, 32'd1);
    checkReg("status_count1", STATUS_A, modelStatus(1, 1'b0, 1'b0));
    @(negedge cpu_clk);
    checkOutput("start_bit_at_t2", {31'd0, uart_tx}, 32'd0);
    repeat (39) @(negedge cpu_clk);
    checkReg("busy_at_39", STATUS_A, modelStatus(0, 1'b0, 1'b1));
    @(negedge cpu_clk);
    checkReg("idle_at_40", STATUS_A, modelStatus(0, 1'b0, 1'b0));

    $display("[TB] overflow with transmitter disabled");
    applyStimulus(CTRL_A, 2'b10, 32'd0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      applyStimulus(TXDATA_A, 2'($urandom_range(0, 3)), {24'($urandom), b});
      if (model_fifo.size() < DEPTH) model_fifo.push_back(b);
      else model_ovf = 1'b1;
    end
    checkReg("status_overflow", STATUS_A, modelStatus(model_fifo.size(), model_ovf, 1'b0));
    applyStimulus(STATUS_A, 2'b10, 32'hFFFF_FFF7);
    checkReg("ovf_kept_bit3_zero", STATUS_A, modelStatus(model_fifo.size(), model_ovf, 1'b0));
    applyStimulus(STATUS_A, 2'b10, 32'h0000_0008);
    model_ovf = 1'b0;
    checkReg("ovf_cleared", STATUS_A, modelStatus(model_fifo.size(), model_ovf, 1'b0));

    $display("[TB] push into full FIFO on the pop cycle");
    applyStimulus(DIV_A, 2'b01, 32'd1);
    cur_div = 16'd1;
    while (model_fifo.size() > 0) exp_q.push_back('{data: model_fifo.pop_front(), p: 1});
    applyStimulus(CTRL_A, 2'b10, 32'd1);
    exp_q.push_back('{data: 8'h5A, p: 1});
    applyStimulus(TXDATA_A, 2'b00, 32'h0000_005A);
    checkReg("full_push_with_pop", STATUS_A, modelStatus(DEPTH, 1'b0, 1'b1));
    waitIdle(500);
    checkReg("drained_status", STATUS_A, modelStatus(0, 1'b0, 1'b0));

    $display("[TB] clearing tx_en mid-frame");
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    pushByte(b1, 1);
    applyStimulus(TXDATA_A, 2'b00, {24'd0, b2});
    applyStimulus(TXDATA_A, 2'b00, {24'd0, b3});
    applyStimulus(CTRL_A, 2'b10, 32'd0);
    waitIdle(200);
    repeat (20) @(negedge cpu_clk);
    checkReg("held_after_disable", STATUS_A, modelStatus(2, 1'b0, 1'b0));
    exp_q.push_back('{data: b2, p: 1});
    exp_q.push_back('{data: b3, p: 1});
    applyStimulus(CTRL_A, 2'b10, 32'd1);
    waitIdle(200);

    $display("[TB] back-to-back frames and irq");
    applyStimulus(DIV_A, 2'b10, 32'd2);
    cur_div = 16'd2;
    applyStimulus(CTRL_A, 2'b10, 32'd3);
    repeat (2) @(negedge cpu_clk);
    checkOutput("irq_idle_enabled", {31'd0, irq}, 32'd1);
    start_q.delete();
    for (int i = 0; i < 3; i++) pushByte(8'($urandom), 2);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge cpu_clk);
      readReg(STATUS_A, s);
      n = k;
      if (exp_q.size() == 0 && s[0] == 1'b0) break;
    end
    checkOutput("b2b_finished", {31'd0, (n < 299)}, 32'd1);
    checkOutput("irq_lags_idle", {31'd0, irq}, 32'd0);
    @(negedge cpu_clk);
    checkOutput("irq_after_stop", {31'd0, irq}, 32'd1);
    checkOutput("b2b_frame_count", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      checkOutput("gap_1_2", 32'(start_q[1] - start_q[0]), 32'd20);
      checkOutput("gap_2_3", 32'(start_q[2] - start_q[1]), 32'd20);
    end

    $display("[TB] divisor change mid-frame");
    applyStimulus(CTRL_A, 2'b10, 32'd1);
    start_q.delete();
    pushByte(8'($urandom), 2);
    pushByte(8'($urandom), 7);
    applyStimulus(DIV_A, 2'b10, 32'd7);
    cur_div = 16'd7;
    waitIdle(500);
    checkOutput("midframe_frame_count", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) checkOutput("old_period_kept", 32'(start_q[1] - start_q[0]), 32'd20);
    applyStimulus(DIV_A, 2'b00, 32'hFFFF_FF03);
    checkReg("div_byte_write", DIV_A, 32'h0000_0003);
    applyStimulus(DIV_A, 2'b10, 32'hABCD_0005);
    checkReg("div_word_write", DIV_A, 32'h0000_0005);
    applyStimulus(DIV_A, 2'b11, 32'hFFFF_0006);
    checkReg("div_mask11_write", DIV_A, 32'h0000_0006);
    cur_div = 16'd6;
    applyStimulus(CTRL_A, 2'b00, 32'hFFFF_FFFE);
    checkReg("ctrl_byte_write", CTRL_A, 32'h0000_0002);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 6; r++) begin
      w = {16'($urandom), 8'h00, 8'($urandom_range(0, 5))};
      m = 2'($urandom_range(0, 3));
      applyStimulus(DIV_A + 32'($urandom_range(0, 3)), m, w);
      cur_div = (m == 2'b00) ? {cur_div[15:8], w[7:0]} : w[15:0];
      applyStimulus(CTRL_A, 2'($urandom_range(0, 3)), {30'($urandom), 2'b01});
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1)
          applyStimulus(TXDATA_A + 32'h10, 2'b00, 32'($urandom));
        pushByte(8'($urandom), effP(cur_div));
        repeat ($urandom_range(0, 3)) @(negedge cpu_clk);
      end
      waitIdle(2000);
      checkReg("rand_divisor", DIV_A, {16'd0, cur_div});
      checkReg("rand_status", STATUS_A, modelStatus(0, 1'b0, 1'b0));
    end

    $display("[TB] reset during DATA");
    mon_en = 1'b0;
    applyStimulus(DIV_A, 2'b10, 32'd4);
    applyStimulus(CTRL_A, 2'b10, 32'd1);
    applyStimulus(TXDATA_A, 2'b00, 32'h0000_003C);
    applyStimulus(TXDATA_A, 2'b00, 32'h0000_0055);
    repeat (10) @(negedge cpu_clk);
    checkOutput("data_bit_low_before_rst", {31'd0, uart_tx}, 32'd0);
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    checkOutput("rst_line_high", {31'd0, uart_tx}, 32'd1);
    cpu_rst = 1'b0;
    cur_div = 16'd868;
    checkReg("rst2_status", STATUS_A, 32'h0000_0004);
    checkReg("rst2_divisor", DIV_A, 32'd868);
    checkReg("rst2_ctrl", CTRL_A, 32'd0);
    lows = 0;
    repeat (100) begin
      @(negedge cpu_clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checkOutput("no_resume_after_rst", 32'(lows), 32'd0);
    checkOutput("rst2_irq", {31'd0, irq}, 32'd0);
    mon_en = 1'b1;

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
